input_pixel_queue: RTL and testbench

INPUT_PIXEL_QUEUE -- requirements
Module: input_pixel_queue

---
 rtl/input_pixel_queue.sv | 128 ++++++++++++
 tb/tb_input_pixel_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/input_pixel_queue.sv
// input_pixel_queue: collects the raster addresses of active pixels for one
// image, then hands them to Layer 1 in order, one address per dequeue.
// While the block is in LOAD it accepts pixels. While it is in READY it
// serves the address queue. After the queue drains it returns to LOAD.
module input_pixel_queue #(
  parameter int          PIXELS     = 784,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  THRESHOLD  = 8'd127
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixelValid,
  input  logic [7:0]            pixelIn,
  output logic                  pixelReady,
  input  logic                  dequeue,
  output logic [ADDR_WIDTH-1:0] queueOut,
  output logic                  queueEmpty,
  output logic                  inputsReady,
  output logic                  emptyImage
);

  // The count must reach PIXELS itself, so it needs one more value than an address.
  localparam int CNT_W = $clog2(PIXELS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXELS - 1);

  typedef enum logic {LOAD, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  empty_image_q, empty_image_d;
  logic                  active;
  logic                  push;

  // Address storage. It has no reset, because a stale entry is never read
  // before it is overwritten.
  logic [ADDR_WIDTH-1:0] mem [0:PIXELS-1];

  // Next-state logic, pointer logic and handshake outputs for the LOAD/READY controller
  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    pix_d         = pix_q;
    cnt_d         = cnt_q;
    empty_image_d = 1'b0;
    pixelReady    = 1'b0;
    inputsReady   = 1'b0;
    push          = 1'b0;
    active        = (pixelIn > THRESHOLD);

    case (state_q)
      LOAD: begin
        pixelReady = 1'b1;
        if (pixelValid) begin
          if (active) begin
            push  = 1'b1;
            wp_d  = wp_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (pix_q == LAST_PIX) begin
            pix_d = '0;
            if (cnt_d != '0) begin
              state_d = READY;
            end else begin
              // An image with no active pixels produces no work for Layer 1.
              // Report the empty image and stay ready for the next image.
              empty_image_d = 1'b1;
              wp_d          = '0;
              rp_d          = '0;
            end
          end else begin
            pix_d = pix_q + ADDR_WIDTH'(1);
          end
        end
      end
      READY: begin
        inputsReady = 1'b1;
        if (dequeue && (cnt_q != '0)) begin
          rp_d  = rp_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // The last entry is leaving. Rewind both pointers so the next image starts at 0.
            state_d = LOAD;
            wp_d    = '0;
            rp_d    = '0;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Controller state register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      wp_q          <= '0;
      rp_q          <= '0;
      pix_q         <= '0;
      cnt_q         <= '0;
      empty_image_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      pix_q         <= pix_d;
      cnt_q         <= cnt_d;
      empty_image_q <= empty_image_d;
    end
  end

  // Write the raster index of each active pixel at the tail of the queue
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q] <= pix_q;
    end
  end

  assign queueOut   = mem[rp_q];
  assign queueEmpty = (cnt_q == '0);
  assign emptyImage = empty_image_q;

endmodule

// File: tb/tb_input_pixel_queue.sv
// Testbench for input_pixel_queue. Each scenario pushes its expected
// addresses into a scoreboard queue. A separate monitor pops one entry from
// that queue for each dequeue the DUT serves, and compares it with queueOut.
module tb_input_pixel_queue;

  localparam int PIXELS = 784;
  localparam int AW     = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixelValid;
  logic [7:0]    pixelIn;
  logic          pixelReady;
  logic          dequeue;
  logic [AW-1:0] queueOut;
  logic          queueEmpty;
  logic          inputsReady;
  logic          emptyImage;

  int n_checks = 0;
  int n_fail   = 0;
  int empty_cycles = 0;
  int not_ready_cycles = 0;
  int exp_q[$];
  logic [7:0] img [0:PIXELS-1];

  input_pixel_queue #(.PIXELS(PIXELS), .ADDR_WIDTH(AW), .THRESHOLD(8'd127)) dut (
    .clk(clk), .reset(reset), .pixelValid(pixelValid), .pixelIn(pixelIn),
    .pixelReady(pixelReady), .dequeue(dequeue), .queueOut(queueOut),
    .queueEmpty(queueEmpty), .inputsReady(inputsReady), .emptyImage(emptyImage)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: compares queueOut with the scoreboard on every served pop
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && inputsReady && !queueEmpty && dequeue) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop: got %0d expected nothing (scoreboard empty)", queueOut);
        end else begin
          check("pop", int'(queueOut), exp_q.pop_front());
        end
      end
      if (emptyImage) empty_cycles++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_img();
    for (int i = 0; i < PIXELS; i++) img[i] = 8'd0;
  endtask

  // Drives the first n pixels of img. A one-cycle bubble is inserted every 97 pixels.
  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      if ((i % 97) == 50) begin
        @(negedge clk);
        pixelValid = 1'b0;
      end
      @(negedge clk);
      #1;
      if (!pixelReady) not_ready_cycles++;
      pixelValid = 1'b1;
      pixelIn    = img[i];
    end
    @(negedge clk);
    pixelValid = 1'b0;
    pixelIn    = 8'd0;
  endtask

  task automatic wait_inputs_ready(input string name);
    int budget = 20;
    while (!inputsReady && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #2;
    check(name, int'(inputsReady), 1);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dequeue = 1'b1;
    end
    @(negedge clk);
    dequeue = 1'b0;
    #3;
  endtask

  task automatic check_drained(input string tag);
    check({tag, " queueEmpty"}, int'(queueEmpty), 1);
    check({tag, " inputsReady"}, int'(inputsReady), 0);
    check({tag, " scoreboard left"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; pixelValid = 1'b0; pixelIn = 8'd0; dequeue = 1'b0;
    #7;
    check("reset pixelReady", int'(pixelReady), 1);
    check("reset inputsReady", int'(inputsReady), 0);
    check("reset queueEmpty", int'(queueEmpty), 1);
    check("reset emptyImage", int'(emptyImage), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #2;
    check("post-reset pixelReady", int'(pixelReady), 1);

    // Scenario A: pixels 5, 300 and 783 are active. The bench drives pixelValid in READY and it must be ignored.
    clear_img(); img[5] = 8'd200; img[300] = 8'd200; img[783] = 8'd200;
    exp_q.push_back(5); exp_q.push_back(300); exp_q.push_back(783);
    empty_cycles = 0; not_ready_cycles = 0;
    send_pixels(PIXELS);
    wait_inputs_ready("A inputsReady");
    check("A head", int'(queueOut), 5);
    check("A queueEmpty", int'(queueEmpty), 0);
    check("A pixelReady stalls", not_ready_cycles, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); pixelValid = 1'b1; pixelIn = 8'd255;
    end
    @(negedge clk); pixelValid = 1'b0; #2;
    check("A valid-in-READY pixelReady", int'(pixelReady), 0);
    check("A valid-in-READY inputsReady", int'(inputsReady), 1);
    check("A valid-in-READY head", int'(queueOut), 5);
    drain(3);
    check_drained("A");
    check("A emptyImage", empty_cycles, 0);

    // Scenario B: an all-zero image. dequeue is driven while the block is in LOAD first.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dequeue = 1'b1;
    end
    @(negedge clk); dequeue = 1'b0; #2;
    check("B deq-in-LOAD queueEmpty", int'(queueEmpty), 1);
    check("B deq-in-LOAD pixelReady", int'(pixelReady), 1);
    clear_img();
    empty_cycles = 0;
    send_pixels(PIXELS);
    repeat (5) @(negedge clk);
    #2;
    check("B emptyImage cycles", empty_cycles, 1);
    check("B inputsReady", int'(inputsReady), 0);
    check("B pixelReady", int'(pixelReady), 1);
    check("B queueEmpty", int'(queueEmpty), 1);

    // Scenario C: the threshold boundary. A value of 127 is inactive and 128 is active.
    clear_img(); img[20] = 8'd127; img[21] = 8'd128; img[600] = 8'd127;
    exp_q.push_back(21);
    empty_cycles = 0;
    send_pixels(PIXELS);
    wait_inputs_ready("C inputsReady");
    check("C head", int'(queueOut), 21);
    drain(1);
    check_drained("C");

    // Scenario D: every pixel is 255. The bench drains 784 entries, then issues one extra dequeue.
    for (int i = 0; i < PIXELS; i++) img[i] = 8'd255;
    for (int i = 0; i < PIXELS; i++) exp_q.push_back(i);
    send_pixels(PIXELS);
    wait_inputs_ready("D inputsReady");
    drain(PIXELS - 1);
    check("D one left queueEmpty", int'(queueEmpty), 0);
    check("D one left head", int'(queueOut), 783);
    drain(2);
    check_drained("D");
    check("D pixelReady after extra deq", int'(pixelReady), 1);

    // Scenario E: reset is pulsed after 400 pixels. Then a full image is sent with pixel 10 active.
    for (int i = 0; i < PIXELS; i++) img[i] = 8'd255;
    send_pixels(400);
    @(negedge clk); reset = 1'b1; #2;
    check("E in-reset pixelReady", int'(pixelReady), 1);
    check("E in-reset queueEmpty", int'(queueEmpty), 1);
    @(negedge clk); reset = 1'b0;
    clear_img(); img[10] = 8'd255;
    exp_q.push_back(10);
    send_pixels(PIXELS);
    wait_inputs_ready("E inputsReady");
    check("E head", int'(queueOut), 10);
    drain(1);
    check_drained("E");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
